// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequencer for the multi-cycle multiply and divide units.
// Accepts one MULT/DIV request, stalls the pipeline while the selected unit
// runs, then sign-corrects the result and writes the HI/LO pair.
// Divide-by-zero is caught before the divider is started.
// Optional feature macro: MULDIV_SIGNED_EN (two's-complement operands with
// magnitude hand-off and result sign correction). Undefined = unsigned.
module muldiv_ctrl #(
    parameter int DIV_CYCLES  = 34,
    parameter int MULT_CYCLES = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_start,
    input  logic        op_mult,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        abort,
    output logic [31:0] div_n,
    output logic [31:0] div_d,
    output logic        div_init,
    output logic        div_stop,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    output logic [31:0] mult_x,
    output logic [31:0] mult_y,
    output logic        mult_init,
    output logic        mult_stop,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        divzero
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        RUN     = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    // Counter reload values: RUN lasts N cycles including the terminal zero.
    localparam logic [5:0] DIV_RELOAD  = 6'(DIV_CYCLES - 1);
    localparam logic [5:0] MULT_RELOAD = 6'(MULT_CYCLES - 1);

    // Two's-complement conditional negation helpers.
    function automatic logic [31:0] cneg32(input logic [31:0] v, input logic neg);
        logic [31:0] res;
        if (neg) res = 32'd0 - v;
        else     res = v;
        return res;
    endfunction

    function automatic logic [63:0] cneg64(input logic [63:0] v, input logic neg);
        logic [63:0] res;
        if (neg) res = 64'd0 - v;
        else     res = v;
        return res;
    endfunction

    state_t      state_r, state_s;
    logic [5:0]  cnt_r, cnt_s;
    logic        mult_r, mult_s;
    logic        sign_a_r, sign_a_s, sign_b_r, sign_b_s;
    logic [31:0] div_n_r, div_n_s, div_d_r, div_d_s;
    logic [31:0] mult_x_r, mult_x_s, mult_y_r, mult_y_s;
    logic [31:0] hi_r, hi_s, lo_r, lo_s;
    logic        div_init_r, div_init_s, div_stop_r, div_stop_s;
    logic        mult_init_r, mult_init_s, mult_stop_r, mult_stop_s;
    logic        busy_r, busy_s, done_r, done_s, divzero_r, divzero_s;
    logic [31:0] mag_a_s, mag_b_s;
    logic        neg_a_s, neg_b_s;
    logic [31:0] quo_s, rem_s;
    logic [63:0] prod_s;

    // Operand interpretation: magnitudes and sign flags handed to the units.
    always_comb begin
`ifdef MULDIV_SIGNED_EN
        neg_a_s = a[31];
        neg_b_s = b[31];
`else
        neg_a_s = 1'b0;
        neg_b_s = 1'b0;
`endif
        mag_a_s = cneg32(a, neg_a_s);
        mag_b_s = cneg32(b, neg_b_s);
    end

    // Result sign correction: quotient/product by sign xor, remainder follows the dividend.
    always_comb begin
        quo_s  = cneg32(div_lo, sign_a_r ^ sign_b_r);
        rem_s  = cneg32(div_hi, sign_a_r);
        prod_s = cneg64({mult_hi, mult_lo}, sign_a_r ^ sign_b_r);
    end

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        mult_s      = mult_r;
        sign_a_s    = sign_a_r;
        sign_b_s    = sign_b_r;
        div_n_s     = div_n_r;
        div_d_s     = div_d_r;
        mult_x_s    = mult_x_r;
        mult_y_s    = mult_y_r;
        hi_s        = hi_r;
        lo_s        = lo_r;
        div_init_s  = 1'b0;
        div_stop_s  = 1'b0;
        mult_init_s = 1'b0;
        mult_stop_s = 1'b0;
        done_s      = 1'b0;
        divzero_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (op_start && !op_mult && (b == 32'd0)) begin
                    divzero_s = 1'b1;
                end else if (op_start) begin
                    mult_s      = op_mult;
                    sign_a_s    = neg_a_s;
                    sign_b_s    = neg_b_s;
                    div_init_s  = !op_mult;
                    mult_init_s = op_mult;
                    if (op_mult) begin
                        mult_x_s = mag_a_s;
                        mult_y_s = mag_b_s;
                    end else begin
                        div_n_s = mag_a_s;
                        div_d_s = mag_b_s;
                    end
                    state_s = LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                if (abort) begin
                    div_stop_s  = !mult_r;
                    mult_stop_s = mult_r;
                    state_s     = IDLE;
                end else begin
                    cnt_s   = mult_r ? MULT_RELOAD : DIV_RELOAD;
                    state_s = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    div_stop_s  = !mult_r;
                    mult_stop_s = mult_r;
                    cnt_s       = 6'd0;
                    state_s     = IDLE;
                end else if (cnt_r == 6'd0) begin
                    state_s = CAPTURE;
                end else begin
                    cnt_s = cnt_r - 6'd1;
                end
            end
            CAPTURE: begin
                if (abort) begin
                    div_stop_s  = !mult_r;
                    mult_stop_s = mult_r;
                end else if (mult_r) begin
                    hi_s   = prod_s[63:32];
                    lo_s   = prod_s[31:0];
                    done_s = 1'b1;
                end else begin
                    hi_s   = rem_s;
                    lo_s   = quo_s;
                    done_s = 1'b1;
                end
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 6'd0;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // State and registered-output update; reset clears everything to idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            cnt_r       <= 6'd0;
            mult_r      <= 1'b0;
            sign_a_r    <= 1'b0;
            sign_b_r    <= 1'b0;
            div_n_r     <= 32'd0;
            div_d_r     <= 32'd0;
            mult_x_r    <= 32'd0;
            mult_y_r    <= 32'd0;
            hi_r        <= 32'd0;
            lo_r        <= 32'd0;
            div_init_r  <= 1'b0;
            div_stop_r  <= 1'b0;
            mult_init_r <= 1'b0;
            mult_stop_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            divzero_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            mult_r      <= mult_s;
            sign_a_r    <= sign_a_s;
            sign_b_r    <= sign_b_s;
            div_n_r     <= div_n_s;
            div_d_r     <= div_d_s;
            mult_x_r    <= mult_x_s;
            mult_y_r    <= mult_y_s;
            hi_r        <= hi_s;
            lo_r        <= lo_s;
            div_init_r  <= div_init_s;
            div_stop_r  <= div_stop_s;
            mult_init_r <= mult_init_s;
            mult_stop_r <= mult_stop_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            divzero_r   <= divzero_s;
        end
    end

    assign div_n     = div_n_r;
    assign div_d     = div_d_r;
    assign div_init  = div_init_r;
    assign div_stop  = div_stop_r;
    assign mult_x    = mult_x_r;
    assign mult_y    = mult_y_r;
    assign mult_init = mult_init_r;
    assign mult_stop = mult_stop_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign hi        = hi_r;
    assign lo        = lo_r;
    assign divzero   = divzero_r;

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencer for the multi-cycle multiply and divide units sitting beside the ALU. Accepts one MULT/DIV request from the main control unit and stalls the pipeline while the selected unit runs. Starts and aborts that unit, waits its fixed latency, then sign-corrects the result and writes the architectural HI/LO pair. Detects division by zero before starting the divider and reports it as a one-cycle exception pulse.

## Interface
Parameters:
- DIV_CYCLES, 34, cycles the divider needs from its init pulse to valid hi/lo (1..63)
- MULT_CYCLES, 33, cycles the multiplier needs from its init pulse to valid hi/lo (1..63)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- op_start  in  1  request pulse, sampled only in IDLE
- op_mult  in  1  1 = MULT, 0 = DIV; sampled with op_start
- a, b  in  32  operands (dividend/divisor or multiplicands); sampled with op_start
- abort  in  1  pipeline flush; cancels an operation in flight
- div_n, div_d  out  32  registered operand magnitudes to divider
- div_init, div_stop  out  1  one-cycle pulses to divider
- div_hi, div_lo  in  32  divider remainder / quotient
- mult_x, mult_y  out  32  registered operand magnitudes to multiplier
- mult_init, mult_stop  out  1  one-cycle pulses to multiplier
- mult_hi, mult_lo  in  32  multiplier product, upper / lower word
- busy  out  1  stall request; high in every state except IDLE
- done  out  1  one-cycle completion pulse
- hi, lo  out  32  architectural HI/LO registers
- divzero  out  1  one-cycle divide-by-zero exception pulse

## Operation
- States: IDLE, LOAD, RUN, CAPTURE.
- IDLE, op_start=1, op_mult=0, b==0: no divider start. divzero pulses next cycle, hi/lo unchanged, stay IDLE, busy stays 0.
- IDLE, op_start=1, otherwise: register operand magnitudes (see Configuration), sign flags and op_mult. Go to LOAD.
- LOAD: assert div_init or mult_init for one cycle. Load counter with DIV_CYCLES-1 or MULT_CYCLES-1. Go to RUN.
- RUN: decrement counter; at 0 go to CAPTURE.
- CAPTURE: sample unit outputs, apply sign correction, write hi/lo, pulse done, return to IDLE.
- Divide: hi = remainder, lo = quotient. Multiply: {hi,lo} = 64-bit product.
- abort in LOAD/RUN/CAPTURE: pulse div_stop/mult_stop (selected unit) for one cycle, go IDLE, no write, no done. abort wins over a simultaneous completion. abort in IDLE is ignored.
- op_start outside IDLE is ignored.

## Timing
- Edge E0 samples op_start. Init pulse occurs in cycle E0..E1. done and the hi/lo update occur at edge E0+N+2 (N = DIV_CYCLES or MULT_CYCLES). busy is high from E0 until that edge.
- divzero is asserted from E0 to E1. busy is never raised for it.
- Reset (rst=0, any time, including mid-operation): state IDLE, counter 0, hi=lo=0, div_n/div_d/mult_x/mult_y=0. busy, done, divzero and all init/stop pulses are 0. Unit outputs are ignored until the next start.
- Back-to-back: a new op_start is accepted in the cycle after done.

## Configuration
- MULDIV_SIGNED_EN defined: operands are treated as two's complement. Units receive magnitudes. Quotient is negated if sign(a)^sign(b). Remainder takes the sign of a. 64-bit product is negated if signs differ. -2^31 / -1 gives lo=0x80000000, hi=0.
- Undefined: all operands unsigned, passed unchanged, no result correction.

## Test plan
- Reset mid-RUN: DIV 100/7 started, rst low at E0+10 -> busy=0, hi=lo=0 immediately; no done afterwards.
- Unsigned DIV a=100, b=7 with model divider -> done at E0+36, lo=14, hi=2, busy high E0..E0+36.
- DIV b=0 -> divzero pulse at E0..E1, div_init never asserted, hi/lo keep prior values, busy 0.
- MULT a=0xFFFFFFFF, b=2: signed build -> {hi,lo}=0xFFFFFFFF_FFFFFFFE; unsigned build -> 0x00000001_FFFFFFFE; done at E0+35.
- Signed DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- abort at the same edge as completion -> div_stop pulses, no done, hi/lo unchanged; next op_start accepted one cycle later.
